// File: rtl/adc_frame_pkg.sv
// Shared types and helpers for the LTC ADC frame aligner behind the ISERDES receiver.
package adc_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED
    } state_t;

    localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

    // Lane A carries the odd sample bits, lane B the even ones.
    function automatic logic [15:0] interleave(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[2*k+1] = a[k];
            r[2*k]   = b[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_frame_aligner.sv
// Bitslips the ISERDES until the frame word matches, tracks lock, and re-interleaves
// the two DDR lanes into 16-bit samples.
module adc_frame_aligner
    import adc_frame_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
    parameter int         SLIP_WAIT     = 16,
    parameter int         MATCH_COUNT   = 64,
    parameter int         LOSS_COUNT    = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  frame_word,
    input  logic [7:0]  data_a,
    input  logic [7:0]  data_b,
    output logic        bitslip,
    output logic        locked,
    output logic        align_err,
    output logic [3:0]  slip_count,
    output logic [15:0] sample_out,
    output logic        sample_valid
);

    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int RW = $clog2(MAX_SLIPS + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
    localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [RW-1:0] ROT_LAST   = RW'(MAX_SLIPS - 1);

    state_t        state;
    logic [MW-1:0] match_cnt;
    logic [LW-1:0] loss_cnt;
    logic [WW-1:0] wait_cnt;
    logic [RW-1:0] rot_cnt;
    logic          match;

    assign match = (frame_word == FRAME_PATTERN);

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            match_cnt    <= '0;
            loss_cnt     <= '0;
            wait_cnt     <= '0;
            rot_cnt      <= '0;
            bitslip      <= 1'b0;
            locked       <= 1'b0;
            align_err    <= 1'b0;
            slip_count   <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= enable & locked;
            if (enable) begin
                sample_out <= interleave(data_a, data_b);
            end
            // NOTE: default-low here makes bitslip a one-cycle pulse; only SLIP raises it.
            bitslip <= 1'b0;

            if (!enable) begin
                state      <= IDLE;
                match_cnt  <= '0;
                loss_cnt   <= '0;
                wait_cnt   <= '0;
                rot_cnt    <= '0;
                locked     <= 1'b0;
                align_err  <= 1'b0;
                slip_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CHECK;
                    end
                    CHECK: begin
                        if (match) begin
                            rot_cnt <= '0;
                            if (match_cnt == MATCH_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                loss_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= SLIP;
                        end
                    end
                    SLIP: begin
                        bitslip  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT;
                        if (slip_count != 4'hF) begin
                            slip_count <= slip_count + 4'd1;
                        end
                        // A full rotation without any match means the pattern can never align.
                        if (rot_cnt == ROT_LAST) begin
                            align_err <= 1'b1;
                            rot_cnt   <= '0;
                        end else begin
                            rot_cnt <= rot_cnt + RW'(1);
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state <= CHECK;
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            loss_cnt <= '0;
                            rot_cnt  <= '0;
                        end else if (loss_cnt == LOSS_LAST) begin
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            loss_cnt  <= '0;
                            state     <= SLIP;
                        end else begin
                            loss_cnt <= loss_cnt + LW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner; the ISERDES bitslip is modelled as a
// rotate-left of the frame and lane words after each observed pulse.
module tb_adc_frame_aligner;

    logic        sample_clk;
    logic        reset;
    logic        enable;
    logic [7:0]  frame_word;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic        bitslip;
    logic        locked;
    logic        align_err;
    logic [3:0]  slip_count;
    logic [15:0] sample_out;
    logic        sample_valid;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int pulses   = 0;
    int pulse_cyc[$];
    int took;
    int c0;
    int sp1;
    int sp2;
    int first_off;

    adc_frame_aligner dut (
        .sample_clk  (sample_clk),
        .reset       (reset),
        .enable      (enable),
        .frame_word  (frame_word),
        .data_a      (data_a),
        .data_b      (data_b),
        .bitslip     (bitslip),
        .locked      (locked),
        .align_err   (align_err),
        .slip_count  (slip_count),
        .sample_out  (sample_out),
        .sample_valid(sample_valid)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rol(input logic [7:0] w);
        return {w[6:0], w[7]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and apply the bitslip model.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sample_clk);
            #1;
            cycle++;
            if (bitslip === 1'b1) begin
                pulses++;
                pulse_cyc.push_back(cycle);
                frame_word = rol(frame_word);
                data_a     = rol(data_a);
                data_b     = rol(data_b);
            end
        end
    endtask

    task automatic wait_locked(input string tag, input int budget, output int n);
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 16'(locked), 16'd1);
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (pulses < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 16'(pulses), 16'(target));
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step(2);
        reset  = 1'b0;
        step(1);
        pulses = 0;
        pulse_cyc.delete();
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        frame_word = 8'h00;
        data_a     = 8'h00;
        data_b     = 8'h00;
        step(2);

        // Reset state
        check("rst_bitslip",   16'(bitslip),      16'd0);
        check("rst_locked",    16'(locked),       16'd0);
        check("rst_align_err", 16'(align_err),    16'd0);
        check("rst_slip_cnt",  16'(slip_count),   16'd0);
        check("rst_sample",    sample_out,        16'h0000);
        check("rst_valid",     16'(sample_valid), 16'd0);
        reset = 1'b0;
        step(1);

        // 1: pre-aligned frame locks after 64 matches with no slips
        frame_word = 8'hF0;
        data_a     = 8'h00;
        data_b     = 8'h0D;
        enable     = 1'b1;
        step(64);
        check("t1_not_yet_locked", 16'(locked), 16'd0);
        step(1);
        check("t1_locked",         16'(locked),       16'd1);
        check("t1_valid_lags",     16'(sample_valid), 16'd0);
        step(1);
        check("t1_valid",          16'(sample_valid), 16'd1);
        check("t1_sample",         sample_out,        16'h0051);
        check("t1_no_pulses",      16'(pulses),       16'd0);

        // 2: frame rotated by three bits
        do_reset();
        frame_word = 8'h1E;
        data_a     = 8'h81;
        data_b     = 8'h00;
        c0         = cycle;
        enable     = 1'b1;
        wait_locked("t2_lock", 300, took);
        check("t2_lock_latency", 16'(took),   16'd119);
        check("t2_pulse_count",  16'(pulses), 16'd3);
        first_off = (pulse_cyc.size() >= 1) ? pulse_cyc[0] - c0 : -1;
        sp1       = (pulse_cyc.size() >= 2) ? pulse_cyc[1] - pulse_cyc[0] : -1;
        sp2       = (pulse_cyc.size() >= 3) ? pulse_cyc[2] - pulse_cyc[1] : -1;
        check("t2_first_pulse",  16'(first_off),  16'd3);
        check("t2_spacing_1",    16'(sp1),        16'd18);
        check("t2_spacing_2",    16'(sp2),        16'd18);
        check("t2_slip_count",   16'(slip_count), 16'd3);
        step(1);
        check("t2_valid",        16'(sample_valid), 16'd1);
        check("t2_sample",       sample_out,        16'h00A0);

        // 5b: drop enable while locked; new lane data shows the sample holds
        enable = 1'b0;
        data_a = 8'hFF;
        data_b = 8'hFF;
        step(1);
        check("t5b_locked",    16'(locked),       16'd0);
        check("t5b_bitslip",   16'(bitslip),      16'd0);
        check("t5b_slip_cnt",  16'(slip_count),   16'd0);
        check("t5b_align_err", 16'(align_err),    16'd0);
        check("t5b_valid",     16'(sample_valid), 16'd0);
        check("t5b_hold",      sample_out,        16'h00A0);
        pulses = 0;
        enable = 1'b1;
        wait_locked("t5b_relock", 200, took);
        check("t5b_relock_latency", 16'(took),       16'd65);
        check("t5b_relock_slips",   16'(slip_count), 16'd0);

        // 4: loss-of-lock hysteresis
        frame_word = 8'h00;
        step(3);
        check("t4_3miss_locked", 16'(locked), 16'd1);
        frame_word = 8'hF0;
        step(1);
        check("t4_match_locked", 16'(locked), 16'd1);
        frame_word = 8'h00;
        step(3);
        check("t4_3miss_again",  16'(locked), 16'd1);
        step(1);
        check("t4_4miss_drop",   16'(locked),  16'd0);
        check("t4_no_pulse_yet", 16'(bitslip), 16'd0);
        frame_word = 8'hF0;
        step(1);
        check("t4_pulse",        16'(bitslip),    16'd1);
        check("t4_slip_count",   16'(slip_count), 16'd1);

        // 3: unalignable frame word
        do_reset();
        frame_word = 8'hAA;
        data_a     = 8'h3C;
        data_b     = 8'hC3;
        enable     = 1'b1;
        wait_pulses("t3_seven_pulses", 7, 400);
        check("t3_err_before",   16'(align_err),  16'd0);
        check("t3_slips_7",      16'(slip_count), 16'd7);
        wait_pulses("t3_eighth_pulse", 8, 40);
        check("t3_err_set",      16'(align_err),  16'd1);
        check("t3_slips_8",      16'(slip_count), 16'd8);
        wait_pulses("t3_keep_slipping", 20, 400);
        check("t3_saturated",    16'(slip_count), 16'hF);
        check("t3_err_sticky",   16'(align_err),  16'd1);
        check("t3_never_locked", 16'(locked),     16'd0);
        enable = 1'b0;
        step(1);
        check("t3_err_cleared",  16'(align_err),  16'd0);
        check("t3_slips_clear",  16'(slip_count), 16'd0);

        // 5a: asynchronous reset while the first bitslip pulse is high (in WAIT)
        pulses     = 0;
        frame_word = 8'h1E;
        data_a     = 8'h12;
        data_b     = 8'h34;
        enable     = 1'b1;
        wait_pulses("t5a_first_pulse", 1, 50);
        #2;
        reset = 1'b1;
        #1;
        check("t5a_bitslip",   16'(bitslip),      16'd0);
        check("t5a_locked",    16'(locked),       16'd0);
        check("t5a_slip_cnt",  16'(slip_count),   16'd0);
        check("t5a_align_err", 16'(align_err),    16'd0);
        check("t5a_sample",    sample_out,        16'h0000);
        check("t5a_valid",     16'(sample_valid), 16'd0);
        step(1);
        frame_word = 8'hF0;
        reset      = 1'b0;
        pulses     = 0;
        wait_locked("t5a_relock", 200, took);
        check("t5a_relock_latency", 16'(took),   16'd65);
        check("t5a_relock_pulses",  16'(pulses), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
